// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and default adder geometry.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SEG_W_DEF = 8;
    localparam int CLA_GRP_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } alu_op_e;

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead segment made of 4-bit lookahead groups;
// group generate/propagate ripple the carry between groups.
module cla_seg
    import alu_pkg::*;
#(
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    localparam int NGRP = SEG_W / CLA_GRP_W;

    logic [SEG_W-1:0] p_s;
    logic [SEG_W-1:0] g_s;
    logic [SEG_W:0]   c_s;
    logic [NGRP-1:0]  gp_s;
    logic [NGRP-1:0]  gg_s;
    int               base_s;

    // Bit P/G, in-group lookahead carries and group P/G carry chain.
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s    = '0;
        gp_s   = '0;
        gg_s   = '0;
        base_s = 0;
        c_s[0] = cin;
        for (int grp = 0; grp < NGRP; grp++) begin
            base_s        = grp * CLA_GRP_W;
            gg_s[grp]     = g_s[base_s+3]
                          | (p_s[base_s+3] & g_s[base_s+2])
                          | (p_s[base_s+3] & p_s[base_s+2] & g_s[base_s+1])
                          | (p_s[base_s+3] & p_s[base_s+2] & p_s[base_s+1] & g_s[base_s]);
            gp_s[grp]     = &p_s[base_s +: CLA_GRP_W];
            c_s[base_s+1] = g_s[base_s] | (p_s[base_s] & c_s[base_s]);
            c_s[base_s+2] = g_s[base_s+1]
                          | (p_s[base_s+1] & g_s[base_s])
                          | (p_s[base_s+1] & p_s[base_s] & c_s[base_s]);
            c_s[base_s+3] = g_s[base_s+2]
                          | (p_s[base_s+2] & g_s[base_s+1])
                          | (p_s[base_s+2] & p_s[base_s+1] & g_s[base_s])
                          | (p_s[base_s+2] & p_s[base_s+1] & p_s[base_s] & c_s[base_s]);
            c_s[base_s+4] = gg_s[grp] | (gp_s[grp] & c_s[base_s]);
        end
        sum  = p_s ^ c_s[SEG_W-1:0];
        cout = c_s[SEG_W];
    end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined segmented CLA adder/subtractor with valid/ready backpressure.
// Optional saturation on signed overflow when PIPE_ADD_SAT_EN is defined.
module pipe_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
`ifdef PIPE_ADD_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSTAGE = WIDTH / SEG_W;

    logic                             stall_s;
    logic [WIDTH-1:0]                 b_eff_s;
    logic                             cin_s;
    logic [NSTAGE-1:0]                v_r;
    logic [NSTAGE-1:0][WIDTH-1:0]     x_r;   // resolved low segments + pending a segments
    logic [NSTAGE-1:0]                c_r;
    logic [NSTAGE-1:0][SEG_W-1:0]     seg_sum_s;
    logic [NSTAGE-1:0]                seg_cout_s;
    logic [NSTAGE-1:0][WIDTH-1:0]     nx_s;
    logic [WIDTH-1:0]                 fin_sum_s;
    logic                             fin_ovf_s;
    logic                             a_msb_s;
    logic                             b_msb_s;
    logic                             out_valid_r;
    logic [WIDTH-1:0]                 out_sum_r;
    logic                             out_carry_r;
    logic                             out_ovf_r;

    assign stall_s   = out_valid_r & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_carry = out_carry_r;
    assign out_ovf   = out_ovf_r;
    assign out_zero  = out_valid_r & (out_sum_r == {WIDTH{1'b0}});

    // Operand conditioning: subtraction is a + ~b + cin.
    always_comb begin
        b_eff_s = in_b;
        cin_s   = 1'b0;
        case (alu_op_e'(in_op))
            OP_ADD:  begin b_eff_s = in_b;  cin_s = 1'b0;     end
            OP_SUB:  begin b_eff_s = ~in_b; cin_s = 1'b1;     end
            OP_ADC:  begin b_eff_s = in_b;  cin_s = in_carry; end
            OP_SBB:  begin b_eff_s = ~in_b; cin_s = in_carry; end
            default: begin b_eff_s = in_b;  cin_s = 1'b0;     end
        endcase
    end

    // b skew registers shrink by one segment per stage as segments resolve.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int BW = WIDTH - k * SEG_W;
        logic [BW-1:0] b_r;

        if (k == 0) begin : g_first
            // Capture the conditioned b operand at accept.
            always_ff @(posedge clk) begin
                if (reset) begin
                    b_r <= '0;
                end else if (!stall_s) begin
                    b_r <= b_eff_s;
                end
            end
        end else begin : g_next
            // Forward the still-unresolved b segments.
            always_ff @(posedge clk) begin
                if (reset) begin
                    b_r <= '0;
                end else if (!stall_s) begin
                    b_r <= g_stg[k-1].b_r[BW+SEG_W-1:SEG_W];
                end
            end
        end

        cla_seg #(.SEG_W(SEG_W)) u_cla (
            .a    (x_r[k][k*SEG_W +: SEG_W]),
            .b    (b_r[SEG_W-1:0]),
            .cin  (c_r[k]),
            .sum  (seg_sum_s[k]),
            .cout (seg_cout_s[k])
        );
    end

    // Splice each stage's freshly resolved segment into its result vector.
    always_comb begin
        nx_s = x_r;
        for (int k = 0; k < NSTAGE; k++) begin
            nx_s[k][k*SEG_W +: SEG_W] = seg_sum_s[k];
        end
    end

`ifdef PIPE_ADD_SAT_EN
    logic [NSTAGE-1:0] sat_r;

    // Saturation request travels with its beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_r <= '0;
        end else if (!stall_s) begin
            sat_r <= {sat_r[NSTAGE-2:0], in_sat};
        end
    end
`endif

    // Final stage: operand sign bits are still in the skew registers here.
    always_comb begin
        a_msb_s   = x_r[NSTAGE-1][WIDTH-1];
        b_msb_s   = g_stg[NSTAGE-1].b_r[SEG_W-1];
        fin_ovf_s = (a_msb_s == b_msb_s) & (nx_s[NSTAGE-1][WIDTH-1] != a_msb_s);
        fin_sum_s = nx_s[NSTAGE-1];
`ifdef PIPE_ADD_SAT_EN
        if (sat_r[NSTAGE-1] && fin_ovf_s) begin
            fin_sum_s          = {WIDTH{~a_msb_s}};
            fin_sum_s[WIDTH-1] = a_msb_s;
        end else begin
            fin_sum_s = nx_s[NSTAGE-1];
        end
`endif
    end

    // Pipeline advance: every stage and the output register hold together on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_r         <= '0;
            x_r         <= '0;
            c_r         <= '0;
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_carry_r <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else if (!stall_s) begin
            v_r[0] <= in_valid;
            x_r[0] <= in_a;
            c_r[0] <= cin_s;
            for (int k = 1; k < NSTAGE; k++) begin
                v_r[k] <= v_r[k-1];
                x_r[k] <= nx_s[k-1];
                c_r[k] <= seg_cout_s[k-1];
            end
            out_valid_r <= v_r[NSTAGE-1];
            out_sum_r   <= fin_sum_s;
            out_carry_r <= seg_cout_s[NSTAGE-1];
            out_ovf_r   <= fin_ovf_s;
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub: directed corner cases, ADC chaining with a
// mid-stream stall, reset with beats in flight, and random traffic with backpressure.
module tb_pipe_add_sub;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef PIPE_ADD_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        logic         zero;
        logic         lat;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_carry;
    logic         in_sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;
    logic         out_zero;

    exp_t sb_q[$];
    exp_t e_m;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   lat_chk;
    bit   done;

    always #5 clk = ~clk;

    pipe_add_sub dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_carry  (in_carry),
`ifdef PIPE_ADD_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: full-precision unsigned and signed arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci, input logic sat);
        exp_t   e;
        longint ua, ub, sa, sb, ur, sr, c;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00)      c = 64'sd0;
        else if (op == 2'b01) c = 64'sd1;
        else                  c = ci ? 64'sd1 : 64'sd0;
        if (op[0]) begin
            ur      = ua - ub - (64'sd1 - c);
            sr      = sa - sb - (64'sd1 - c);
            e.carry = (ur >= 64'sd0);
        end else begin
            ur      = ua + ub + c;
            sr      = sa + sb + c;
            e.carry = (ur > 64'sd4294967295);
        end
        e.sum = ur[31:0];
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (SAT_EN && sat && e.ovf) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.zero = (e.sum == 32'h0);
        e.lat  = 1'b0;
        e.cyc  = 0;
        return e;
    endfunction

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sat, output exp_t e);
        bit got = 1'b0;
        e = model(op, a, b, ci, sat);
        in_op = op; in_a = a; in_b = b; in_carry = ci; in_sat = sat; in_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.lat = lat_chk;
                e.cyc = cyc + 5;
                sb_q.push_back(e);
                got = 1'b1;
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb_q.size() > 0; t++) @(negedge clk);
        check("drain_left", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom());
        endcase
    endfunction

    // Output scoreboard: the head entry must be presented, and held, until taken.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_beat", 64'd1, 64'd0);
            end else begin
                e_m = sb_q[0];
                check("sum",   64'(out_sum),   64'(e_m.sum));
                check("carry", 64'(out_carry), 64'(e_m.carry));
                check("ovf",   64'(out_ovf),   64'(e_m.ovf));
                check("zero",  64'(out_zero),  64'(e_m.zero));
                if (!out_ready) begin
                    check("in_ready_stall", 64'(in_ready), 64'd0);
                end else begin
                    if (e_m.lat) check("latency", 64'(cyc), 64'(e_m.cyc));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic c;
        reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        in_carry = 1'b0; in_sat = 1'b0; out_ready = 1'b1; lat_chk = 1'b1; done = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum",   64'(out_sum),   64'd0);
        check("rst_carry", 64'(out_carry), 64'd0);
        check("rst_ovf",   64'(out_ovf),   64'd0);
        check("rst_zero",  64'(out_zero),  64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed corners
        send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
        send(OP_SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, e);
        send(OP_SUB, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b0, e);
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, e);
        send(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, e);
        send(OP_SBB, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, e);
        send(OP_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, e);
        send(OP_ADD, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, e);
        drain();

        // ADC chain, no stall: back-to-back accepts with fixed latency
        c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(OP_ADC, W'($urandom()) | 32'h8000_0000, W'($urandom()), c, 1'b0, e);
            c = e.carry;
        end
        drain();

        // ADC chain with a 3-cycle consumer stall mid-stream
        lat_chk = 1'b0;
        c = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(OP_ADC, W'($urandom()), W'($urandom()), c, 1'b0, e);
                    c = e.carry;
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight
        lat_chk = 1'b1;
        send(OP_ADD, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, e);
        send(OP_SUB, 32'h0000_0030, 32'h0000_0001, 1'b0, 1'b0, e);
        send(OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, e);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("inflight_rst_valid", 64'(out_valid), 64'd0);
        check("inflight_rst_sum",   64'(out_sum),   64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(OP_ADD, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, e);
        drain();

        // Random traffic with idle gaps and random backpressure
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), e);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_add_sub.md
Name: pipe_add_sub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the next-generation replacement for the fixed 32-bit combinational ALU adder.
- Operand width is split into SEG_W-bit segments; one segment resolves per pipeline stage, with the carry registered between stages.
- Valid/ready handshake with full backpressure.
- Sits in the ALU execute path between operand select and result writeback.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SEG_W
SEG_W, 8, bits resolved per pipeline stage (CLA segment width); must be a multiple of 4
NSTAGE, WIDTH/SEG_W, derived (localparam): pipeline depth and latency in cycles

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
in_op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_carry  in  1  carry/not-borrow input, used by ADC/SBB only
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  result
out_carry  out  1  carry out of MSB; for SUB/SBB 1 means no borrow
out_ovf  out  1  signed overflow
out_zero  out  1  out_sum == 0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. On reset, all stage valid bits clear. out_valid=0 and out_sum/out_carry/out_ovf/out_zero=0 in the cycle after reset is sampled. in_ready=1 while reset is low and the pipe is empty.
- Operand conditioning at accept:
  - b_eff = in_b for ADD/ADC; ~in_b for SUB/SBB.
  - cin = 0 for ADD, 1 for SUB, in_carry for ADC/SBB.
- Stage k (0..NSTAGE-1):
  - Adds segment k of a and b_eff with the carry registered from stage k-1 (stage 0 uses cin).
  - Registers the segment sum, carry out and a valid bit.
  - Upper, unresolved operand segments are carried forward in skew registers.
  - Lower result segments are carried forward alongside.
- Latency: a beat accepted at edge N produces out_valid=1 after edge N+NSTAGE, assuming no stall.
- Throughput: one beat per cycle.
- Stall:
  - stall = out_valid & ~out_ready.
  - When stall=1, every stage register holds and in_ready=0.
  - in_ready = ~stall; accept = in_valid & in_ready.
  - Bubbles propagate as valid=0 and are not compacted.
- out_* hold stable while out_valid=1 and out_ready=0. This is an AXI-style hold; the consumer may rely on it.
- Flags:
  - out_ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]). a[MSB] and b_eff[MSB] are carried to the last stage.
  - out_zero is computed combinationally from out_sum.
- Wrap-around: the sum is taken modulo 2^WIDTH. The carry is reported, never saturated, unless ADD_SAT_EN applies.
- Simultaneous events:
  - A new accept and an output handoff in the same cycle are both allowed; the pipe shifts.
  - Reset overrides all; in-flight beats are discarded, not emitted.
- in_valid with in_ready=0: the beat is not captured. The producer must hold it.

Optional Feature:
Macro PIPE_ADD_SAT_EN.
- Defined:
  - Adds input port in_sat (1 bit), captured with the beat.
  - When in_sat=1 and the final stage detects signed overflow, out_sum = 0x7FF..F if a[MSB]=0, else 0x800..0.
  - out_ovf still reports 1; out_carry is unchanged.
- Not defined: no in_sat port and no saturation logic; behaviour is pure wrap-around.

Decomposition:
- Package alu_pkg:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBB=2'b11.
  - Default WIDTH/SEG_W constants.
- Sub-module cla_seg (parameter SEG_W):
  - Combinational SEG_W-bit carry-lookahead segment built from 4-bit lookahead groups with group P/G.
  - Outputs sum[SEG_W-1:0] and cout.
  - Instantiated NSTAGE times via generate.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x00000000, carry=1, zero=1, ovf=0.
- SUB 5 - 7 -> sum=0xFFFFFFFE, carry=0 (borrow), ovf=0; SUB 7 - 5 -> sum=2, carry=1.
- ADD 0x7FFFFFFF + 1 -> sum=0x80000000, ovf=1; with PIPE_ADD_SAT_EN and in_sat=1 -> sum=0x7FFFFFFF, ovf=1.
- 8 back-to-back beats with ADC chaining in_carry -> 8 consecutive out_valid cycles, results in order; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, out_* stable, no beat lost or duplicated.
- Assert reset with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted after release; next beat returns after 4 cycles.
- Random ops at WIDTH=64, SEG_W=16 against a reference model -> sum, carry, ovf and zero all match for 10k beats.
